// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer carrying a control bundle and a payload
// with valid/ready handshake, freeze (stall) and flush. Entries that are not valid present a zero control bundle, i.e. a NOP.
module pipe_stage_fifo #(
    parameter  int DATA_W = 128,
    parameter  int CTRL_W = 9,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_freeze,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [DATA_W-1:0] o_out_data,
    output logic [CNT_W-1:0]  o_count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [CTRL_W-1:0] r_ctrl_mem [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_last_data;

    logic              w_push;
    logic              w_pop;
    logic              w_out_valid;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;

    // in_ready depends only on occupancy and freeze, never on out_ready
    assign w_out_valid  = (r_count != '0);
    assign o_in_ready   = (r_count < DEPTH_C) & ~i_freeze;
    assign w_push       = i_in_valid & o_in_ready;
    assign w_pop        = w_out_valid & i_out_ready & ~i_freeze;
    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;

    assign o_out_valid = w_out_valid;
    assign o_out_ctrl  = w_out_valid ? r_ctrl_mem[r_rd_ptr] : '0;
    assign o_out_data  = w_out_valid ? r_data_mem[r_rd_ptr] : r_last_data;
    assign o_count     = r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl_mem[i] <= '0;
                r_data_mem[i] <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_data <= '0;
        end else begin
            // keeps out_data showing the most recent head once the buffer drains
            if (w_out_valid) begin
                r_last_data <= r_data_mem[r_rd_ptr];
            end
            if (i_flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_ctrl_mem[i] <= '0;
                end
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_ctrl_mem[r_wr_ptr] <= i_in_ctrl;
                    r_data_mem[r_wr_ptr] <= i_in_data;
                    r_wr_ptr             <= w_wr_ptr_nxt;
                end
                if (w_pop) begin
                    r_rd_ptr <= w_rd_ptr_nxt;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            assert (r_count <= DEPTH_C);
            assert (!(w_push && !w_pop && (r_count == DEPTH_C)));
            assert (!(w_pop && (r_count == '0)));
        end
    end

endmodule
